// File: rtl/sigmoid_pla_pkg.sv
// Shared constants and types for the piecewise-linear sigmoid pipeline.
// Fixed-point sign-magnitude format: 1 sign, INT_BITS integer, FRAC_BITS fraction.
package sigmoid_pla_pkg;

    localparam int FRAC_BITS = 6;
    localparam int INT_BITS  = 5;
    localparam int WIDTH     = 1 + INT_BITS + FRAC_BITS;
    localparam int MAG_W     = WIDTH - 1;
    localparam int P_W       = 7;
    localparam int STAGES    = 3;
    localparam int ONE       = 1 << FRAC_BITS;

    localparam logic [WIDTH-1:0] ONE_SM = WIDTH'(ONE);

    // Segment thresholds on the magnitude: 1.0, 2.375, 5.0
    localparam logic [MAG_W-1:0] T1 = MAG_W'(64);
    localparam logic [MAG_W-1:0] T2 = MAG_W'(152);
    localparam logic [MAG_W-1:0] T3 = MAG_W'(320);

    localparam logic [P_W-1:0] OFF0  = P_W'(32);
    localparam logic [P_W-1:0] OFF1  = P_W'(40);
    localparam logic [P_W-1:0] OFF2  = P_W'(54);
    localparam logic [P_W-1:0] P_ONE = P_W'(ONE);

    typedef enum logic [1:0] {
        SEG0 = 2'd0,
        SEG1 = 2'd1,
        SEG2 = 2'd2,
        SEG3 = 2'd3
    } seg_e;

    function automatic seg_e seg_of(input logic [MAG_W-1:0] m);
        if (m >= T3)      return SEG3;
        else if (m >= T2) return SEG2;
        else if (m >= T1) return SEG1;
        else              return SEG0;
    endfunction

endpackage

// File: rtl/sub_fixed.sv
// Saturating sign-magnitude subtractor: y = a - b, magnitude clamps at full scale.
// Zero results are always emitted as +0.
module sub_fixed #(
    parameter int WIDTH = 12
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             ovf
);
    localparam int MW = WIDTH - 1;

    logic          a_s, b_s, r_s;
    logic [MW-1:0] a_m, b_m, mag;
    logic [MW:0]   sum;

    always_comb begin
        a_s = a[WIDTH-1];
        b_s = ~b[WIDTH-1];   // subtract = add with b negated
        a_m = a[MW-1:0];
        b_m = b[MW-1:0];
        sum = {1'b0, a_m} + {1'b0, b_m};
        ovf = 1'b0;
        r_s = a_s;
        mag = '0;
        if (a_s == b_s) begin
            ovf = sum[MW];
            mag = sum[MW] ? '1 : sum[MW-1:0];
        end else if (a_m >= b_m) begin
            mag = a_m - b_m;
        end else begin
            mag = b_m - a_m;
            r_s = b_s;
        end
        y = {r_s && (mag != '0), mag};
    end

endmodule

// File: rtl/sigmoid_pla_pipe.sv
// 3-stage PLAN sigmoid: classify, evaluate positive half, reflect negatives.
// All stages advance together on en; a stalled output freezes the whole pipe.
module sigmoid_pla_pipe
    import sigmoid_pla_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_x,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic             busy
);
    logic [STAGES:1] vld_pipe;
    logic            en;

    logic             s1_s;
    logic [MAG_W-1:0] s1_m;
    seg_e             s1_seg;
    logic             s2_s;
    logic [P_W-1:0]   s2_p;
    logic [P_W-1:0]   p_nx;
    logic [WIDTH-1:0] refl_y;
    logic             sub_ovf_unused;

    assign en        = !vld_pipe[STAGES] || out_ready;
    assign in_ready  = en;
    assign out_valid = vld_pipe[STAGES];
    assign busy      = |vld_pipe;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_pipe <= '0;
        else if (en) vld_pipe <= {vld_pipe[STAGES-1:1], in_valid};
    end

    // Stage 1: -0 folds to +0 so it evaluates exactly like +0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_s   <= 1'b0;
            s1_m   <= '0;
            s1_seg <= SEG0;
        end else if (en && in_valid) begin
            s1_s   <= in_x[WIDTH-1] && (|in_x[WIDTH-2:0]);
            s1_m   <= in_x[WIDTH-2:0];
            s1_seg <= seg_of(in_x[WIDTH-2:0]);
        end
    end

    always_comb begin
        p_nx = P_ONE;
        case (s1_seg)
            SEG0: p_nx = P_W'(s1_m >> 2) + OFF0;
            SEG1: p_nx = P_W'(s1_m >> 3) + OFF1;
            SEG2: p_nx = P_W'(s1_m >> 5) + OFF2;
            SEG3: p_nx = P_ONE;
            default: p_nx = P_ONE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_s <= 1'b0;
            s2_p <= '0;
        end else if (en && vld_pipe[1]) begin
            s2_s <= s1_s;
            s2_p <= p_nx;
        end
    end

    sub_fixed #(.WIDTH(WIDTH)) u_refl (
        .a   (ONE_SM),
        .b   (WIDTH'(s2_p)),
        .y   (refl_y),
        .ovf (sub_ovf_unused)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) out_y <= '0;
        else if (en && vld_pipe[2]) out_y <= s2_s ? refl_y : WIDTH'(s2_p);
    end

endmodule

// File: doc/sigmoid_pla_pipe.md
Name: sigmoid_pla_pipe

Overview:
- 3-stage pipelined piecewise-linear (PLAN) sigmoid evaluator in the LSTM gate datapath.
- Consumes sign-magnitude fixed-point gate pre-activations: 1 sign, 5 integer, 6 fraction bits; 1.0 = 64.
- Produces sigmoid(x) in the same format.
- Negative inputs use the reflection 1.0 - sigmoid(|x|), computed by an instance of the team's saturating sign-magnitude subtractor.
- Valid/ready on both sides for backpressure from the downstream gate multiplier.

Parameters:
- WIDTH, 12, total bits (sign + magnitude).
- FRAC_BITS, 6, fractional bits; ONE = 1 << FRAC_BITS.
- INT_BITS, 5, integer bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_x  in  WIDTH  sign-magnitude input x.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_y  out  WIDTH  sign-magnitude sigmoid(x); sign bit always 0.
- busy  out  1  any pipeline stage holds valid data.

Behaviour:
- Reset, asynchronous: all stage valid bits 0, all data regs 0. Outputs: out_valid=0, out_y=0, busy=0, in_ready=1.
- Advance enable: en = !out_valid || out_ready. in_ready = en, combinational. Every stage advances together only when en=1; when en=0 all stages hold, so there is no data loss and no duplication.
- Transfer in: in_valid && in_ready. Transfer out: out_valid && out_ready.
- Bubbles propagate as valid=0. Latency is exactly 3 cycles from input accept to out_valid when out_ready stays 1. Throughput is 1 sample per cycle.
- Stage 1 (capture/classify):
  - Register sign s and magnitude m = in_x[WIDTH-2:0].
  - Negative zero (0x800) is treated as +0 (s forced to 0).
  - Segment select on m:
    - seg3 if m >= 320 (5.0)
    - seg2 if m >= 152 (2.375)
    - seg1 if m >= 64 (1.0)
    - else seg0.
- Stage 2 (positive-half evaluation), unsigned, truncating shifts:
  - seg0: p = (m >> 2) + 32
  - seg1: p = (m >> 3) + 40
  - seg2: p = (m >> 5) + 54
  - seg3: p = 64
  - p is held in 7 bits; p never exceeds 64.
- Stage 3 (reflection):
  - s=0: y = {0, p}.
  - s=1: y = subtractor(ONE, {0, p}). The subtractor overflow output is ignored; the result is always in 0..64 with sign 0.
  - The subtractor is combinational, fed from stage-2 regs; its result is registered into out_y.
- out_y is held stable while out_valid && !out_ready.
- busy = OR of the three stage valid bits.
- Simultaneous accept and emit in the same cycle is legal and is the steady state.
- rst_n asserted mid-stream flushes all in-flight samples immediately. No output is produced for them after release.
- in_x is don't-care when in_valid=0. No X may propagate into valid bits.

Decomposition:
- Shared package/include: WIDTH, FRAC_BITS, INT_BITS, ONE (64), thresholds T1=64, T2=152, T3=320, offsets 32/40/54, and the 2-bit segment encoding.
- Sub-module: one instance of sub_fixed, the existing sign-magnitude saturating subtractor, for the reflection in stage 3.
- Pipeline control (en, valid shift) stays inline.

Test Plan:
- Single samples with out_ready=1:
  - 0x000 -> 0x020 after exactly 3 cycles
  - 0x040 (+1.0) -> 0x030
  - 0x840 (-1.0) -> 0x010
  - 0x020 (+0.5) -> 0x028
  - 0x0C0 (+3.0) -> 0x03C
- Saturation: 0x180 (+6.0) -> 0x040; 0x980 (-6.0) -> 0x000; 0x7FF -> 0x040; 0x800 (-0) -> 0x020.
- Segment boundaries:
  - 63 -> 47; 64 -> 48
  - 151 -> 58; 152 -> 58
  - 319 -> 63; 320 -> 64
  - each boundary also checked with sign set: result = 64 - positive result.
- Back-to-back stream of 16 random samples with out_ready=1: one result per cycle, in order, matching a reference model.
- Backpressure: out_ready=0 for 5 cycles with 3 samples in flight. Required: in_ready=0, out_y stable, busy=1. After out_ready returns to 1, results drain in order with no loss or duplication.
- Async reset: assert rst_n low mid-stream, between clock edges. Required: out_valid and busy drop immediately, in_ready=1. After release, the first new sample emerges 3 cycles after accept.
